// File: rtl/encoder16x4_serial_if.sv
// Handshake bundle for encoder16x4_serial: request vector in, index beats out.
// master drives req_valid/req_data/out_ready; slave is the encoder side.
interface encoder16x4_serial_if #(
  parameter int N_IN  = 16,
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [N_IN-1:0]  req_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_zero
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_zero
  );
endinterface

// File: rtl/encoder16x4_serial.sv
// Serial 16-to-4 priority encoder: walks every set bit of a request vector
// and emits one 4-bit index per beat, lowest first.
// Ports: clk, rst (sync, active-high), bus (encoder16x4_serial_if.slave).
// Build option: define ENCODER_MSB_FIRST_EN for highest-bit-first order.
module encoder16x4_serial (
  input  logic                 clk,
  input  logic                 rst,
  encoder16x4_serial_if.slave  bus
);
  localparam int N_IN  = 16;
  localparam int IDX_W = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [N_IN-1:0] ONE = N_IN'(1);

  logic [0:0]       state;
  logic [N_IN-1:0]  pend;
  logic [IDX_W-1:0] sel;
  logic             zero;
  logic             one_hot;
  logic             last;
  logic             emit;

  // Priority pick; the loop direction makes the last match win.
  always_comb begin
    sel = '0;
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < N_IN; i++)
      if (pend[i]) sel = IDX_W'(i);
`else
    for (int i = N_IN - 1; i >= 0; i--)
      if (pend[i]) sel = IDX_W'(i);
`endif
  end

  assign zero    = (pend == '0);
  assign one_hot = !zero &&
                   ((pend & (pend - ONE)) == '0);
  // A zero vector still produces a single closing beat.
  assign last    = one_hot || zero;

  // Outputs are forced low while reset is held.
  assign emit          = (state == EMIT) && !rst;
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.out_valid = emit;
  assign bus.out_idx   = emit ? sel : '0;
  assign bus.out_last  = emit && last;
  assign bus.out_zero  = emit && zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            pend  <= bus.req_data;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pend[sel] <= 1'b0;
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encoder16x4_serial.sv
// Self-checking bench for encoder16x4_serial.
// Expected beats are queued at stimulus time and popped on accepted beats.
module tb_encoder16x4_serial;
  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic       zero;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  encoder16x4_serial_if bus ();

  encoder16x4_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  function automatic void push_vec(input logic [15:0] v);
    int    left;
    beat_t b;
    left = $countones(v);
    if (v == 16'h0) begin
      b = '{idx: 4'd0, last: 1'b1, zero: 1'b1};
      exp_q.push_back(b);
      return;
    end
    for (int k = 0; k < 16; k++) begin
      int i;
`ifdef ENCODER_MSB_FIRST_EN
      i = 15 - k;
`else
      i = k;
`endif
      if (v[i]) begin
        b.idx  = 4'(i);
        b.last = (left == 1);
        b.zero = 1'b0;
        exp_q.push_back(b);
        left--;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers v until the encoder is ready, then drops req_valid.
  task automatic send(input logic [15:0] v);
    bit ok;
    ok = 0;
    bus.req_valid = 1'b1;
    bus.req_data  = v;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1;
      else tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout req_ready never seen for %h", v);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = 16'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.out_valid, bus.out_idx,
         bus.out_last, bus.out_zero} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b idx=%0d l=%b z=%b want all 0",
               bus.req_ready, bus.out_valid, bus.out_idx,
               bus.out_last, bus.out_zero);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b v=%b want 1/0",
               bus.req_ready, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_basic(input logic [15:0] v, input int nb);
    beat_t e;
    beat_t cur;
    bus.out_ready = 1'b1;
    push_vec(v);
    send(v);
    for (int c = 0; c < nb; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_valid vec=%h c=%0d v=%b rdy=%b want 1/0",
                 v, c, bus.out_valid, bus.req_ready);
      end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        cur = {bus.out_idx, bus.out_last, bus.out_zero};
        checks++;
        if (cur !== e) begin
          errors++;
          $display("FAIL basic_beat vec=%h got idx=%0d l=%b z=%b want idx=%0d l=%b z=%b",
                   v, cur.idx, cur.last, cur.zero, e.idx, e.last, e.zero);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_bubble vec=%h got v=%b rdy=%b want 0/1",
               v, bus.out_valid, bus.req_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_count vec=%h got %0d beats left want 0",
               v, exp_q.size());
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_stall();
    beat_t e;
    beat_t cur;
    beat_t held;
    bit    have;
    int    acc;
    have = 0;
    acc  = 0;
    held = '0;
    push_vec(16'hFFFF);
    bus.out_ready = 1'b1;
    send(16'hFFFF);
    for (int c = 0; c < 64 && acc < 16; c++) begin
      bus.out_ready = (c % 2 == 0);
      @(negedge clk);
      cur = {bus.out_idx, bus.out_last, bus.out_zero};
      if (have) begin
        checks++;
        if (cur !== held || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold got idx=%0d l=%b v=%b want idx=%0d l=%b v=1",
                   cur.idx, cur.last, bus.out_valid, held.idx, held.last);
        end
        have = 0;
      end
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stall_extra got idx=%0d want no beat", cur.idx);
        end else if (bus.out_ready) begin
          e = exp_q.pop_front();
          acc++;
          checks++;
          if (cur !== e) begin
            errors++;
            $display("FAIL stall_beat got idx=%0d l=%b z=%b want idx=%0d l=%b z=%b",
                     cur.idx, cur.last, cur.zero, e.idx, e.last, e.zero);
          end
        end else begin
          held = cur;
          have = 1;
          checks++;
          if (cur !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_peek got idx=%0d want idx=%0d",
                     cur.idx, exp_q[0].idx);
          end
        end
      end
      tick();
    end
    bus.out_ready = 1'b1;
    checks++;
    if (acc != 16) begin
      errors++;
      $display("FAIL stall_count got %0d beats want 16", acc);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_bubble got rdy=%b v=%b want 1/0",
               bus.req_ready, bus.out_valid);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset_mid();
    beat_t e;
    beat_t cur;
    bit    seen;
    push_vec(16'h0030);
    void'(exp_q.pop_back());
    bus.out_ready = 1'b1;
    send(16'h0030);
    @(negedge clk);
    e   = exp_q.pop_front();
    cur = {bus.out_idx, bus.out_last, bus.out_zero};
    checks++;
    if (bus.out_valid !== 1'b1 || cur !== e) begin
      errors++;
      $display("FAIL rstmid_first got v=%b idx=%0d l=%b want v=1 idx=%0d l=%b",
               bus.out_valid, cur.idx, cur.last, e.idx, e.last);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during got v=%b rdy=%b want 0/0",
               bus.out_valid, bus.req_ready);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after got v=%b rdy=%b want 0/1",
               bus.out_valid, bus.req_ready);
    end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_discard got a stray beat want none");
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_ignore();
    beat_t e;
    beat_t cur;
    bus.out_ready = 1'b1;
    push_vec(16'h0005);
    send(16'h0005);
    bus.req_valid = 1'b1;
    bus.req_data  = 16'hAAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_ready c=%0d got %b want 0", c, bus.req_ready);
      end
      e   = exp_q.pop_front();
      cur = {bus.out_idx, bus.out_last, bus.out_zero};
      checks++;
      if (bus.out_valid !== 1'b1 || cur !== e) begin
        errors++;
        $display("FAIL ignore_beat got v=%b idx=%0d l=%b want v=1 idx=%0d l=%b",
                 bus.out_valid, cur.idx, cur.last, e.idx, e.last);
      end
      tick();
      if (c == 0) begin
        bus.req_data = 16'h00F0;
        push_vec(16'h00F0);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle got rdy=%b v=%b want 1/0",
               bus.req_ready, bus.out_valid);
    end
    tick();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cur = {bus.out_idx, bus.out_last, bus.out_zero};
      checks++;
      if (exp_q.size() == 0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ignore_next c=%0d got v=%b want 1", c, bus.out_valid);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL ignore_next c=%0d got idx=%0d l=%b want idx=%0d l=%b",
                   c, cur.idx, cur.last, e.idx, e.last);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_end got v=%b left=%0d want 0/0",
               bus.out_valid, exp_q.size());
    end
    exp_q.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(16'h8421, 4);
    test_basic(16'h0000, 1);
    test_basic(16'h0001, 1);
    test_basic(16'h8000, 1);
    test_stall();
    test_reset_mid();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
